// File: rtl/dpwm_pkg.sv
// dpwm_pkg: code limits and sequencer state type shared by the DPWM
// sequencer and the DPWM generator.
//   DPWM_DUTY_W / DPWM_DUTY_MAX : duty code width and highest legal code
//   DPWM_FS_W   / DPWM_FS_MAX   : frequency code width and highest legal code
//   seq_state_t                 : sequencer states, encoding visible on o_state
package dpwm_pkg;

    localparam int DPWM_DUTY_W   = 5;
    localparam int DPWM_DUTY_MAX = 19;
    localparam int DPWM_FS_W     = 4;
    localparam int DPWM_FS_MAX   = 9;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRECHARGE = 3'd1,
        ST_RAMP      = 3'd2,
        ST_RUN       = 3'd3,
        ST_STOP      = 3'd4,
        ST_FAULT     = 3'd5
    } seq_state_t;

endpackage

// File: rtl/dpwm_period_counter.sv
// dpwm_period_counter: counts switching periods for the soft-start and
// soft-stop ramps. Only counts when asked; wraps only through i_clear.
//   clk_200  : system clock
//   i_reset  : synchronous active-high reset
//   i_clear  : clear the count (wins over i_count)
//   i_count  : advance by one (one switching-period wrap)
//   o_tc     : count equals RAMP_PERIODS-1
module dpwm_period_counter #(
    parameter int PCNT_W       = 8,
    parameter int RAMP_PERIODS = 4
) (
    input  logic clk_200,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_count,
    output logic o_tc
);

    logic [PCNT_W-1:0] cnt;

    always_ff @(posedge clk_200) begin
        if (i_reset || i_clear) begin
            cnt <= '0;
        end else if (i_count) begin
            cnt <= cnt + PCNT_W'(1);
        end
    end

    assign o_tc = (cnt == PCNT_W'(RAMP_PERIODS - 1));

endmodule

// File: rtl/dpwm_seq_ctrl.sv
// dpwm_seq_ctrl: sequencer/configurator for the dual-output DPWM generator.
// Handles precharge, soft-start ramp, slew-limited duty tracking, soft-stop
// ramp-down and a latched fault shutdown. All outputs are registered.
//   clk_200, i_reset         : clock, synchronous active-high reset
//   i_run                    : 1 = converter on, 0 = soft-stop
//   i_target_duty, i_fs      : requested duty and frequency codes
//   i_cycle_start            : generator switching-period wrap pulse
//   i_fault, i_fault_clr     : fault level, fault acknowledge
//   o_dpwm_reset/_enable     : generator reset and enable
//   o_fs, o_duty, o_update   : generator configuration and duty load strobe
//   o_state, o_fault         : status
module dpwm_seq_ctrl
    import dpwm_pkg::*;
#(
    parameter int DUTY_W       = DPWM_DUTY_W,
    parameter int DUTY_MAX     = DPWM_DUTY_MAX,
    parameter int FS_MAX       = DPWM_FS_MAX,
    parameter int PRE_CYCLES   = 16,
    parameter int RAMP_PERIODS = 4,
    parameter int PCNT_W       = 8
) (
    input  logic              clk_200,
    input  logic              i_reset,
    input  logic              i_run,
    input  logic [DUTY_W-1:0] i_target_duty,
    input  logic [3:0]        i_fs,
    input  logic              i_cycle_start,
    input  logic              i_fault,
    input  logic              i_fault_clr,
    output logic              o_dpwm_reset,
    output logic              o_dpwm_enable,
    output logic [3:0]        o_fs,
    output logic [DUTY_W-1:0] o_duty,
    output logic              o_update,
    output logic [2:0]        o_state,
    output logic              o_fault
);

    localparam int PRE_W = $clog2(PRE_CYCLES + 1);
    localparam logic [DUTY_W-1:0] DUTY_MAX_C = DUTY_W'(DUTY_MAX);

    seq_state_t        st, st_nxt;
    logic [PRE_W-1:0]  pre_cnt, pre_cnt_nxt;
    logic [DUTY_W-1:0] duty_nxt, duty_sat;
    logic [3:0]        fs_nxt;
    logic              step, step_q;
    logic              pc_clr, pc_cnt, pc_tc;

    assign duty_sat = (i_target_duty > DUTY_MAX_C) ? DUTY_MAX_C : i_target_duty;
    assign o_state  = st;

    dpwm_period_counter #(
        .PCNT_W       (PCNT_W),
        .RAMP_PERIODS (RAMP_PERIODS)
    ) u_period_counter (
        .clk_200 (clk_200),
        .i_reset (i_reset),
        .i_clear (pc_clr),
        .i_count (pc_cnt),
        .o_tc    (pc_tc)
    );

    always_ff @(posedge clk_200) begin
        if (i_reset) begin
            st            <= ST_IDLE;
            pre_cnt       <= '0;
            step_q        <= 1'b0;
            o_dpwm_reset  <= 1'b1;
            o_dpwm_enable <= 1'b0;
            o_fs          <= '0;
            o_duty        <= '0;
            o_update      <= 1'b0;
            o_fault       <= 1'b0;
        end else begin
            st            <= st_nxt;
            pre_cnt       <= pre_cnt_nxt;
            step_q        <= step;
            o_dpwm_reset  <= (st_nxt inside {ST_IDLE, ST_PRECHARGE, ST_FAULT});
            o_dpwm_enable <= (st_nxt inside {ST_RAMP, ST_RUN, ST_STOP});
            o_fs          <= fs_nxt;
            o_duty        <= duty_nxt;
            // strobe trails the duty change by one edge; swallowed by a fault
            o_update      <= step_q && (st_nxt != ST_FAULT);
            o_fault       <= (st_nxt == ST_FAULT);
        end
    end

    // Branch order encodes priority: fault, then run level, then period step.
    always_comb begin
        st_nxt      = st;
        pre_cnt_nxt = '0;
        duty_nxt    = o_duty;
        fs_nxt      = o_fs;
        step        = 1'b0;
        pc_clr      = 1'b0;
        pc_cnt      = 1'b0;
        case (st)
            ST_IDLE: begin
                fs_nxt = (i_fs > 4'(FS_MAX)) ? '0 : i_fs;
                if (i_run && !i_fault) st_nxt = ST_PRECHARGE;
            end
            ST_PRECHARGE: begin
                if (i_fault) begin
                    st_nxt = ST_FAULT;
                end else if (pre_cnt == PRE_W'(PRE_CYCLES - 1)) begin
                    st_nxt = ST_RAMP;
                    pc_clr = 1'b1;
                end else begin
                    pre_cnt_nxt = pre_cnt + PRE_W'(1);
                end
            end
            ST_RAMP: begin
                if (i_fault) begin
                    st_nxt = ST_FAULT;
                end else if (!i_run) begin
                    st_nxt = ST_STOP;
                    pc_clr = 1'b1;
                end else if (o_duty >= duty_sat) begin
                    st_nxt = ST_RUN;
                end else if (i_cycle_start) begin
                    if (pc_tc) begin
                        duty_nxt = o_duty + DUTY_W'(1);
                        step     = 1'b1;
                        pc_clr   = 1'b1;
                    end else begin
                        pc_cnt = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (i_fault) begin
                    st_nxt = ST_FAULT;
                end else if (!i_run) begin
                    st_nxt = ST_STOP;
                    pc_clr = 1'b1;
                end else if (i_cycle_start && (o_duty != duty_sat)) begin
                    duty_nxt = (o_duty < duty_sat) ? o_duty + DUTY_W'(1)
                                                   : o_duty - DUTY_W'(1);
                    step     = 1'b1;
                end
            end
            ST_STOP: begin
                if (i_fault) begin
                    st_nxt = ST_FAULT;
                end else if (i_run) begin
                    st_nxt = ST_RAMP;
                    pc_clr = 1'b1;
                end else if (i_cycle_start) begin
                    if (pc_tc) begin
                        pc_clr = 1'b1;
                        if (o_duty == '0) begin
                            st_nxt = ST_IDLE;
                        end else begin
                            duty_nxt = o_duty - DUTY_W'(1);
                            step     = 1'b1;
                        end
                    end else begin
                        pc_cnt = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                if (i_fault_clr && !i_fault && !i_run) st_nxt = ST_IDLE;
            end
            default: st_nxt = ST_IDLE;
        endcase
        if (st_nxt inside {ST_IDLE, ST_PRECHARGE, ST_FAULT}) duty_nxt = '0;
    end

endmodule
